// File: rtl/microseq_pkg.sv
// Shared encodings for the microprogrammed MIPS control sequencer:
// next-state control codes, condition selects, opcodes and encoder target states.
package microseq_pkg;

   localparam int unsigned STATE_W_DEF = 7;

   localparam logic [6:0] RESET_STATE_DEF = 7'd0;
   localparam logic [6:0] FETCH_STATE_DEF = 7'd1;

   typedef enum logic [2:0] {
      NS_ENCODE = 3'b000,
      NS_INCR   = 3'b001,
      NS_JUMP   = 3'b010,
      NS_RETURN = 3'b011,
      NS_CJUMP  = 3'b100,
      NS_CWAIT  = 3'b101,
      NS_CENC   = 3'b110,
      NS_HOLD   = 3'b111
   } ns_ctl_e;

   typedef enum logic [1:0] {
      CS_MOC  = 2'b00,
      CS_COND = 2'b01,
      CS_ZERO = 2'b10,
      CS_ONE  = 2'b11
   } cond_sel_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [6:0] ST_ADD  = 7'd17;
   localparam logic [6:0] ST_ADDU = 7'd6;
   localparam logic [6:0] ST_SUB  = 7'd19;
   localparam logic [6:0] ST_SUBU = 7'd21;
   localparam logic [6:0] ST_AND  = 7'd23;
   localparam logic [6:0] ST_OR   = 7'd25;
   localparam logic [6:0] ST_NOR  = 7'd27;
   localparam logic [6:0] ST_SLT  = 7'd29;
   localparam logic [6:0] ST_LW   = 7'd7;
   localparam logic [6:0] ST_SW   = 7'd13;
   localparam logic [6:0] ST_BEQ  = 7'd11;
   localparam logic [6:0] ST_ADDI = 7'd18;
   localparam logic [6:0] ST_LUI  = 7'd12;

endpackage

// File: rtl/micro_sequencer_encoder.sv
// Instruction decoder: maps the instruction register to the first microstate
// of its execute sequence; valid is low for unsupported encodings.
module instruction_encoder
   import microseq_pkg::*;
(
   input  logic [31:0] ir,
   output logic [6:0]  state,
   output logic        valid
);

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = ir[31:26];
   assign funct = ir[5:0];

   always_comb begin
      state = RESET_STATE_DEF;
      valid = 1'b1;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  state = ST_ADD;
               FN_ADDU: state = ST_ADDU;
               FN_SUB:  state = ST_SUB;
               FN_SUBU: state = ST_SUBU;
               FN_AND:  state = ST_AND;
               FN_OR:   state = ST_OR;
               FN_NOR:  state = ST_NOR;
               FN_SLT:  state = ST_SLT;
               default: valid = 1'b0;
            endcase
         end
         OP_LW:   state = ST_LW;
         OP_SW:   state = ST_SW;
         OP_BEQ:  state = ST_BEQ;
         OP_ADDI: state = ST_ADDI;
         OP_LUI:  state = ST_LUI;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Microstore address sequencer with memory-wait watchdog and illegal-opcode
// detection; one microstate per cycle, registered address output.
module micro_sequencer
   import microseq_pkg::*;
#(
   parameter int unsigned           STATE_W     = STATE_W_DEF,
   parameter logic [STATE_W-1:0]    RESET_STATE = STATE_W'(RESET_STATE_DEF),
   parameter logic [STATE_W-1:0]    FETCH_STATE = STATE_W'(FETCH_STATE_DEF),
   parameter int unsigned           MOC_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         ns_ctl,
   input  logic               inv,
   input  logic [1:0]         cond_sel,
   input  logic [STATE_W-1:0] cr,
   input  logic [31:0]        ir,
   input  logic               moc,
   input  logic               cond_true,
   input  logic               zero,
   output logic [STATE_W-1:0] current_state,
   output logic               mem_timeout,
   output logic               illegal_op
);

   localparam int unsigned        CNT_W    = $clog2(MOC_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

   logic [6:0]         enc_state;
   logic               enc_valid;
   logic [CNT_W-1:0]   wait_cnt;
   logic [CNT_W-1:0]   wait_cnt_next;
   logic [STATE_W-1:0] next_state;
   logic [STATE_W-1:0] incr_state;
   logic               sel;
   logic               c;
   logic               use_enc;
   logic               hold;
   logic               abort;
   logic               illegal;

   instruction_encoder u_encoder (
      .ir    (ir),
      .state (enc_state),
      .valid (enc_valid)
   );

   assign incr_state = current_state + STATE_W'(1);

   always_comb begin
      sel           = 1'b0;
      c             = 1'b0;
      use_enc       = 1'b0;
      hold          = 1'b0;
      abort         = 1'b0;
      illegal       = 1'b0;
      next_state    = current_state;
      wait_cnt_next = '0;

      case (cond_sel_e'(cond_sel))
         CS_MOC:  sel = moc;
         CS_COND: sel = cond_true;
         CS_ZERO: sel = zero;
         default: sel = 1'b1;
      endcase
      c = sel ^ inv;

      case (ns_ctl_e'(ns_ctl))
         NS_ENCODE: use_enc = 1'b1;
         NS_INCR:   next_state = incr_state;
         NS_JUMP:   next_state = cr;
         NS_RETURN: next_state = FETCH_STATE;
         NS_CJUMP:  next_state = c ? cr : incr_state;
         NS_CWAIT: begin
            if (c) next_state = incr_state;
            else   hold = 1'b1;
         end
         NS_CENC: begin
            if (c) next_state = cr;
            else   use_enc = 1'b1;
         end
         default:   next_state = current_state;
      endcase

      // Decode faults only count when the encoder result is actually consumed.
      if (use_enc) begin
         if (enc_valid) begin
            next_state = STATE_W'(enc_state);
         end else begin
            next_state = RESET_STATE;
            illegal    = 1'b1;
         end
      end

      if (hold) begin
         if (wait_cnt == CNT_LAST) begin
            abort      = 1'b1;
            next_state = RESET_STATE;
            illegal    = 1'b0;
         end else begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         current_state <= RESET_STATE;
         wait_cnt      <= '0;
         mem_timeout   <= 1'b0;
         illegal_op    <= 1'b0;
      end else begin
         current_state <= next_state;
         wait_cnt      <= wait_cnt_next;
         mem_timeout   <= abort;
         illegal_op    <= illegal;
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: default instance for sequencing checks,
// a short-timeout instance for watchdog checks, both fed the same stimulus.
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  ns_ctl;
   logic        inv;
   logic [1:0]  cond_sel;
   logic [6:0]  cr;
   logic [31:0] ir;
   logic        moc;
   logic        cond_true;
   logic        zero;

   logic [6:0]  cs_a, cs_b;
   logic        to_a, to_b;
   logic        il_a, il_b;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   micro_sequencer dut_a (
      .clk (clk), .reset (reset), .ns_ctl (ns_ctl), .inv (inv),
      .cond_sel (cond_sel), .cr (cr), .ir (ir), .moc (moc),
      .cond_true (cond_true), .zero (zero),
      .current_state (cs_a), .mem_timeout (to_a), .illegal_op (il_a)
   );

   micro_sequencer #(.MOC_TIMEOUT(4)) dut_b (
      .clk (clk), .reset (reset), .ns_ctl (ns_ctl), .inv (inv),
      .cond_sel (cond_sel), .cr (cr), .ir (ir), .moc (moc),
      .cond_true (cond_true), .zero (zero),
      .current_state (cs_b), .mem_timeout (to_b), .illegal_op (il_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; ns_ctl = 3'b001; inv = 1'b0; cond_sel = 2'b00;
      cr = 7'd0; ir = 32'h0; moc = 1'b0; cond_true = 1'b0; zero = 1'b0;

      // reset held two cycles with INCR requested
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_state", cs_a, 0);
         check("rst_timeout", to_a, 0);
         check("rst_illegal", il_a, 0);
         check("rst_state_b", cs_b, 0);
      end
      reset = 1'b1;
      tick(); check("rel_incr", cs_a, 1);

      // encoder
      ns_ctl = 3'b000; ir = 32'h8C010004;
      tick(); check("enc_lw", cs_a, 7); check("enc_lw_il", il_a, 0);
      ir = 32'h00221820;
      tick(); check("enc_add", cs_a, 17);
      ir = 32'hFC000000;
      tick(); check("enc_bad_state", cs_a, 0); check("enc_bad_il", il_a, 1);
      ns_ctl = 3'b001;
      tick(); check("enc_after_state", cs_a, 1); check("enc_after_il", il_a, 0);

      // memory wait, default timeout
      ns_ctl = 3'b010; cr = 7'd7;
      tick(); check("mw_jump", cs_a, 7);
      ns_ctl = 3'b101; cond_sel = 2'b00; inv = 1'b0; moc = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mw_hold", cs_a, 7);
         check("mw_hold_to", to_a, 0);
      end
      moc = 1'b1;
      tick(); check("mw_adv", cs_a, 8); check("mw_adv_to", to_a, 0);

      // conditional jump on zero
      ns_ctl = 3'b010; cr = 7'd11; moc = 1'b0;
      tick(); check("cj_setup", cs_a, 11);
      ns_ctl = 3'b100; cond_sel = 2'b10; cr = 7'd30; zero = 1'b1;
      tick(); check("cj_taken", cs_a, 30);
      ns_ctl = 3'b010; cr = 7'd11;
      tick();
      ns_ctl = 3'b100; cr = 7'd30; zero = 1'b0;
      tick(); check("cj_not_taken", cs_a, 12);
      ns_ctl = 3'b010; cr = 7'd11;
      tick();
      ns_ctl = 3'b100; cr = 7'd30; zero = 1'b1; inv = 1'b1;
      tick(); check("cj_inverted", cs_a, 12);

      // CENC: taken path never raises illegal_op, fall-through decodes
      ns_ctl = 3'b110; cond_sel = 2'b11; inv = 1'b0; cr = 7'd40; ir = 32'hFC000000;
      tick(); check("cenc_taken", cs_a, 40); check("cenc_taken_il", il_a, 0);
      inv = 1'b1; ir = 32'h10220005;
      tick(); check("cenc_enc", cs_a, 11); check("cenc_enc_il", il_a, 0);
      inv = 1'b0;

      // wrap and return
      ns_ctl = 3'b010; cr = 7'd127;
      tick(); check("wrap_setup", cs_a, 127);
      ns_ctl = 3'b001;
      tick(); check("wrap", cs_a, 0);
      ns_ctl = 3'b011;
      tick(); check("ret_from_0", cs_a, 1);
      ns_ctl = 3'b010; cr = 7'd50;
      tick();
      ns_ctl = 3'b011;
      tick(); check("ret_from_50", cs_a, 1);

      // watchdog, MOC_TIMEOUT = 4
      ns_ctl = 3'b010; cr = 7'd7;
      tick(); check("wd_setup", cs_b, 7);
      ns_ctl = 3'b101; cond_sel = 2'b00; moc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wd_hold", cs_b, 7);
         check("wd_hold_to", to_b, 0);
      end
      tick(); check("wd_abort_state", cs_b, 0); check("wd_abort_to", to_b, 1);
      tick(); check("wd_pulse_end", to_b, 0);

      // moc arriving on the last tolerated cycle wins
      ns_ctl = 3'b010; cr = 7'd7;
      tick();
      ns_ctl = 3'b101;
      for (int i = 0; i < 3; i++) tick();
      check("wd_late_hold", cs_b, 7);
      moc = 1'b1;
      tick(); check("wd_late_adv", cs_b, 8); check("wd_late_to", to_b, 0);

      // reset mid-wait discards the count
      ns_ctl = 3'b010; cr = 7'd7; moc = 1'b0;
      tick();
      ns_ctl = 3'b101;
      tick(); tick();
      reset = 1'b0;
      tick(); check("wd_rst_state", cs_b, 0); check("wd_rst_to", to_b, 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wd_post_rst_to", to_b, 0);
      end
      tick(); check("wd_post_rst_abort", to_b, 1); check("wd_post_rst_state", cs_b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-state address sequencer for the microprogrammed MIPS control unit. Each cycle it registers the 7-bit microstore address from the next-state control fields of the current microinstruction, the status inputs and the instruction register. It drives the microstore address input directly. It also adds a memory-wait watchdog and an illegal-opcode detector.

## Interface
Parameters:
- STATE_W, 7, microstore address width
- RESET_STATE, 7'd0, state entered on reset, watchdog expiry or illegal opcode
- FETCH_STATE, 7'd1, first fetch microstate, target of RETURN
- MOC_TIMEOUT, 64, number of consecutive wait cycles tolerated before abort

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- ns_ctl  input  3  next-state control field from the microstore
- inv  input  1  inverts the selected condition
- cond_sel  input  2  condition select: 00 moc, 01 cond_true, 10 zero, 11 constant 1
- cr  input  STATE_W  target state field from the microstore
- ir  input  32  instruction register
- moc  input  1  memory operation complete
- cond_true  input  1  branch condition from the condition handler
- zero  input  1  ALU zero flag
- current_state  output  STATE_W  registered microstore address
- mem_timeout  output  1  one-cycle pulse on watchdog abort
- illegal_op  output  1  one-cycle pulse when the encoder rejects ir

## Operation
- Condition: c = selected input XOR inv.
- Next-state selection by ns_ctl:
  - 000 ENCODE: next = enc(ir).
  - 001 INCR: next = current_state+1, modulo 2^STATE_W (127 wraps to 0).
  - 010 JUMP: next = cr.
  - 011 RETURN: next = FETCH_STATE.
  - 100 CJUMP: next = c ? cr : current_state+1.
  - 101 CWAIT: next = c ? current_state+1 : current_state (hold).
  - 110 CENC: next = c ? cr : enc(ir).
  - 111 HOLD: next = current_state.
- Encoder enc(ir):
  - Uses op = ir[31:26] and funct = ir[5:0].
  - R-type (op 0x00) by funct: 0x20→17, 0x21→6, 0x22→19, 0x23→21, 0x24→23, 0x25→25, 0x27→27, 0x2A→29.
  - By op: 0x23 LW→7, 0x2B SW→13, 0x04 BEQ→11, 0x08 ADDI→18, 0x0F LUI→12.
  - Any other value: next = RESET_STATE and illegal_op pulses. This is evaluated only when the encoder path is actually selected.
- Watchdog:
  - wait_cnt, width clog2(MOC_TIMEOUT+1), increments on each CWAIT hold cycle.
  - When a hold would occur with wait_cnt == MOC_TIMEOUT-1: next = RESET_STATE, mem_timeout = 1 for that cycle, wait_cnt = 0.
  - wait_cnt clears on any cycle that is not a CWAIT hold.
  - HOLD (111) is not watched.
- Precedence: reset > watchdog abort > illegal opcode > ns_ctl selection.

## Timing
- Reset (reset = 0 at a clock edge):
  - current_state = RESET_STATE, wait_cnt = 0.
  - mem_timeout and illegal_op are registered pulses and reset to 0.
  - Reset mid-wait or mid-decode discards all progress.
- First cycle after reset release: current_state = 0; the microstore supplies state-0 fields combinationally.
- Latency: fields of current_state and status are sampled at edge N; the new current_state is valid after edge N. Exactly one microstate per cycle and no bubbles.
- Pulse outputs are registered at the same edge as the abort state. They are high for exactly the one cycle in which current_state = RESET_STATE due to the abort.
- CWAIT with moc already 1 on entry: advances with no hold.
- moc rising on the cycle with wait_cnt = MOC_TIMEOUT-1: the condition wins, so the state advances and there is no timeout.
- Status inputs must be stable before the edge. The block does no synchronisation.

## Structure
- Package microseq_pkg:
  - ns_ctl codes (NS_ENCODE … NS_HOLD) and cond_sel codes.
  - RESET_STATE and FETCH_STATE defaults.
  - Opcode and funct constants, and the encoder state numbers.
- Sub-module instruction_encoder:
  - Combinational ir → {state[6:0], valid}.
  - Kept separate so the decoder table is edited without touching the sequencer.
- Top level holds the state register, incrementer, condition mux, next-state mux and watchdog.

## Test plan
- Reset: reset = 0 for 2 cycles with ns_ctl = 001 → current_state = 0 throughout and both pulses 0. After release with ns_ctl = 001 → current_state = 1.
- Encode: current_state = 1, ns_ctl = 000, ir = 0x8C010004 (LW) → next state 7. ir = 0x00221820 (ADD) → 17. ir = 0xFC000000 → state 0 with illegal_op high for one cycle.
- Memory wait: state 7, ns_ctl = 101, cond_sel = 00, inv = 0, moc low for 5 cycles then high → state 7 held 5 cycles, then 8. mem_timeout stays 0.
- Watchdog: MOC_TIMEOUT = 4, CWAIT with moc held 0 → state held 3 cycles, then state 0 with mem_timeout = 1 for one cycle. Repeat with moc rising on the 4th cycle → state advances and there is no timeout.
- Conditional jump: state 11, ns_ctl = 100, cond_sel = 10, cr = 30, zero = 1 → 30. zero = 0 → 12. inv = 1 with zero = 1 → 12.
- Wrap/return: state 127, ns_ctl = 001 → 0. ns_ctl = 011 from any state → 1. Reset asserted during a CWAIT hold → state 0 and wait_cnt cleared, checked by a full timeout sequence afterwards.
